// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg
// Shared types and helpers for the SPI register bank.
//   state_e   : frame FSM states
//   RW_WRITE  : R/W bit value selecting a write frame
//   RW_READ   : R/W bit value selecting a read frame
//   frame_w() : total frame length in bits (R/W + address + data)
package spi_reg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } state_e;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  function automatic int frame_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_reg_bank_if.sv
// spi_reg_bank_if
// SPI pin bundle between an SPI controller (master modport) and the
// register bank (slave modport).
//   ncs     : chip select, active low
//   sclk    : SPI clock (mode 0)
//   copi    : controller-out / peripheral-in data
//   cipo    : peripheral-out / controller-in read data
//   cipo_oe : high while the peripheral is driving read data
interface spi_reg_bank_if;
  logic ncs;
  logic sclk;
  logic copi;
  logic cipo;
  logic cipo_oe;

  modport master (
    output ncs,
    output sclk,
    output copi,
    input  cipo,
    input  cipo_oe
  );

  modport slave (
    input  ncs,
    input  sclk,
    input  copi,
    output cipo,
    output cipo_oe
  );
endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge
// Brings one asynchronous input into the clk domain through a
// SYNC_STAGES-deep flop chain and flags its edges.
//   clk     : system clock
//   rst_n   : synchronous active-low reset, loads RST_VAL everywhere
//   i_async : asynchronous input
//   o_level : synchronised level
//   o_rise  : one-clk pulse on a synchronised 0->1 transition
//   o_fall  : one-clk pulse on a synchronised 1->0 transition
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  // Edges compare the last synchronised sample with the one before it,
  // so the metastable first stage never feeds edge logic directly.
  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/spi_reg_bank.sv
// spi_reg_bank
// SPI mode-0 peripheral exposing NUM_REGS x DATA_W configuration
// registers. Frame = R/W bit, ADDR_W address bits, DATA_W data bits,
// MSB first. Writes commit on chip-select release; reads stream the
// addressed register on cipo.
//   clk         : system clock
//   rst_n       : synchronous active-low reset
//   spi         : SPI pins (slave modport)
//   o_regs_q    : flat register contents, reg i at [i*DATA_W +: DATA_W]
//   o_wr_strobe : one-clk pulse when a write commits
//   o_wr_addr   : address of the last committed write
//   o_frame_err : one-clk pulse on a malformed or out-of-range frame
//
// state | meaning
// IDLE  | chip select high, waiting for a frame
// CMD   | shifting in R/W bit and address
// WDATA | shifting in write data
// RDATA | driving read data on cipo, one bit per sclk fall
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int NUM_REGS    = 8,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  spi_reg_bank_if.slave              spi,
  output logic [NUM_REGS*DATA_W-1:0] o_regs_q,
  output logic                       o_wr_strobe,
  output logic [ADDR_W-1:0]          o_wr_addr,
  output logic                       o_frame_err
);

  localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
  // Wide enough to hold FRAME_W+1 so long frames stay distinguishable.
  localparam int CNT_W   = $clog2(FRAME_W + 2);

  localparam logic [CNT_W-1:0] CNT_FRAME    = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_LAST_ADR = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  logic w_ncs_level, w_ncs_rise, w_ncs_fall;
  logic w_sclk_level, w_sclk_rise, w_sclk_fall;
  logic w_copi, w_copi_rise, w_copi_fall;
  logic w_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (spi.ncs),
    .o_level (w_ncs_level),
    .o_rise  (w_ncs_rise),
    .o_fall  (w_ncs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (spi.sclk),
    .o_level (w_sclk_level),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (spi.copi),
    .o_level (w_copi),
    .o_rise  (w_copi_rise),
    .o_fall  (w_copi_fall)
  );

  state_e                r_state, w_state_d;
  logic [CNT_W-1:0]      r_cnt, w_cnt_d;
  logic [FRAME_W-1:0]    r_rx, w_rx_d, w_rx_shift;
  logic [DATA_W-1:0]     r_tx, w_tx_d, w_rd_data;
  logic [ADDR_W-1:0]     r_addr, w_addr_d, w_next_addr;
  logic                  r_rw, w_rw_d;
  logic                  r_cipo, w_cipo_d;
  logic                  r_wr_strobe, w_wr_strobe_d;
  logic [ADDR_W-1:0]     r_wr_addr, w_wr_addr_d;
  logic                  r_frame_err, w_frame_err_d;
  logic                  w_we;
  logic                  w_addr_ok;
  logic [DATA_W-1:0]     r_regs [NUM_REGS];

  // The top frame bit is the R/W flag and is taken from w_rx_shift when
  // the address completes, so the stored copy is never read.
  assign w_unused = &{1'b0, w_sclk_level, w_copi_rise, w_copi_fall, r_rx[FRAME_W-1]};

  assign w_rx_shift  = {r_rx[FRAME_W-2:0], w_copi};
  assign w_next_addr = w_rx_shift[ADDR_W-1:0];
  assign w_addr_ok   = (32'(r_addr) < NUM_REGS);

  // Read mux keyed on the address that is completing this cycle;
  // unimplemented addresses read as zero.
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(w_next_addr) == i) w_rd_data = r_regs[i];
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_rx_d        = r_rx;
    w_tx_d        = r_tx;
    w_addr_d      = r_addr;
    w_rw_d        = r_rw;
    w_cipo_d      = r_cipo;
    w_wr_addr_d   = r_wr_addr;
    w_wr_strobe_d = 1'b0;
    w_frame_err_d = 1'b0;
    w_we          = 1'b0;

    // Chip-select edges take priority; any sclk edge in the same cycle
    // is dropped.
    if (w_ncs_fall) begin
      w_state_d = CMD;
      w_cnt_d   = '0;
      w_rx_d    = '0;
      w_tx_d    = '0;
    end else if (w_ncs_rise) begin
      w_state_d = IDLE;
      w_cipo_d  = 1'b0;
      if (r_state != IDLE) begin
        if ((r_cnt != CNT_FRAME) || !w_addr_ok) begin
          w_frame_err_d = 1'b1;
        end else if (r_rw == RW_WRITE) begin
          w_we          = 1'b1;
          w_wr_strobe_d = 1'b1;
          w_wr_addr_d   = r_addr;
        end
      end
    end else if (!w_ncs_level) begin
      unique case (r_state)
        IDLE: ;
        CMD: begin
          if (w_sclk_rise) begin
            w_rx_d  = w_rx_shift;
            w_cnt_d = r_cnt + CNT_W'(1);
            if (r_cnt == CNT_LAST_ADR) begin
              w_rw_d   = w_rx_shift[ADDR_W];
              w_addr_d = w_next_addr;
              if (w_rx_shift[ADDR_W] == RW_WRITE) begin
                w_state_d = WDATA;
              end else begin
                w_state_d = RDATA;
                w_tx_d    = w_rd_data;
              end
            end
          end
        end
        WDATA: begin
          if (w_sclk_rise) begin
            if (r_cnt < CNT_FRAME) w_rx_d = w_rx_shift;
            if (r_cnt != CNT_MAX) w_cnt_d = r_cnt + CNT_W'(1);
          end
        end
        RDATA: begin
          if (w_sclk_rise && (r_cnt != CNT_MAX)) w_cnt_d = r_cnt + CNT_W'(1);
          // First fall after the last address bit presents the MSB, so
          // the controller samples it on the next rising edge.
          if (w_sclk_fall) begin
            w_cipo_d = r_tx[DATA_W-1];
            w_tx_d   = r_tx << 1;
          end
        end
        default: w_state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rx        <= '0;
      r_tx        <= '0;
      r_addr      <= '0;
      r_rw        <= RW_READ;
      r_cipo      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_frame_err <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_rx        <= w_rx_d;
      r_tx        <= w_tx_d;
      r_addr      <= w_addr_d;
      r_rw        <= w_rw_d;
      r_cipo      <= w_cipo_d;
      r_wr_strobe <= w_wr_strobe_d;
      r_wr_addr   <= w_wr_addr_d;
      r_frame_err <= w_frame_err_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_we && (32'(r_addr) == i)) r_regs[i] <= r_rx[DATA_W-1:0];
      end
    end
  end

  always_comb begin
    o_regs_q = '0;
    for (int i = 0; i < NUM_REGS; i++) o_regs_q[i*DATA_W +: DATA_W] = r_regs[i];
  end

  assign spi.cipo    = r_cipo;
  assign spi.cipo_oe = (r_state == RDATA);
  assign o_wr_strobe = r_wr_strobe;
  assign o_wr_addr   = r_wr_addr;
  assign o_frame_err = r_frame_err;

endmodule
